// File: rtl/rr_arbiter_3to1.sv
// rr_arbiter_3to1: round-robin 3-requester arbiter with hold-limit preemption and registered one-hot grant
module rr_arbiter_3to1 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  input  logic       done_i,
  output logic [2:0] gnt_o,
  output logic [1:0] select_o,
  output logic       busy_o,
  output logic       preempt_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [1:0] ptr, nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0] own_oh, w_idle, w_rel, w_pre, w_hand;
  logic rel, pre, at_lim;
  function automatic logic [2:0] win(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] p1, p2;
    p1 = (p == 2'd2) ? 2'd0 : p + 2'd1;
    p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    return r[p] ? {1'b1, p} : r[p1] ? {1'b1, p1} : r[p2] ? {1'b1, p2} : 3'b000;
  endfunction
  always_comb begin
    own_oh = 3'b001 << select_o;
    nxt = (select_o == 2'd2) ? 2'd0 : select_o + 2'd1;
    w_idle = win(req_i, ptr);
    w_rel = win(req_i, nxt);
    w_pre = win(req_i & ~own_oh, nxt);
    at_lim = cnt == CNT_W'(MAX_HOLD - 1);
    rel = done_i || ~|(req_i & own_oh);
    pre = at_lim && |(req_i & ~own_oh);
    w_hand = rel ? w_rel : w_pre;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= 2'd0;
      cnt <= '0;
      gnt_o <= 3'b000;
      select_o <= 2'd0;
      busy_o <= 1'b0;
      preempt_o <= 1'b0;
    end else begin
      preempt_o <= 1'b0;
      if (state == IDLE) begin
        if (w_idle[2]) begin
          state <= GRANT;
          gnt_o <= 3'b001 << w_idle[1:0];
          select_o <= w_idle[1:0];
          busy_o <= 1'b1;
          cnt <= '0;
        end
      end else if (rel || pre) begin
        ptr <= nxt;
        cnt <= '0;
        preempt_o <= !rel;
        if (w_hand[2]) begin
          gnt_o <= 3'b001 << w_hand[1:0];
          select_o <= w_hand[1:0];
        end else begin
          state <= IDLE;
          gnt_o <= 3'b000;
          busy_o <= 1'b0;
        end
      end else if (!at_lim) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter_3to1.sv
// tb_rr_arbiter_3to1: scoreboard bench comparing the arbiter against a cycle-level behavioural model
module tb_rr_arbiter_3to1;
  localparam int MAX_HOLD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic done = 1'b0;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic busy, preempt;
  typedef struct packed {logic [2:0] g; logic [1:0] s; logic b; logic p;} exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int m_own = -1;
  int m_ptr = 0;
  int m_hold = 0;
  int m_sel = 0;
  bit m_pre = 1'b0;
  rr_arbiter_3to1 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
    .gnt_o(gnt), .select_o(sel), .busy_o(busy), .preempt_o(preempt)
  );
  always #5 clk = ~clk;
  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++)
      if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction
  task automatic model_step(input logic r_rst, input logic [2:0] r_req, input logic r_done);
    int w;
    exp_t e;
    if (r_rst) begin
      m_own = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_own < 0) begin
        w = pick(r_req, m_ptr);
        if (w >= 0) begin m_own = w; m_sel = w; m_hold = 1; end
      end else if (r_done || !r_req[m_own]) begin
        m_ptr = (m_own + 1) % 3;
        w = pick(r_req, m_ptr);
        if (w >= 0) begin m_own = w; m_sel = w; m_hold = 1; end
        else m_own = -1;
      end else if (m_hold >= MAX_HOLD && (r_req & ~(3'b001 << m_own)) != 3'b000) begin
        m_ptr = (m_own + 1) % 3;
        w = pick(r_req & ~(3'b001 << m_own), m_ptr);
        m_own = w; m_sel = w; m_hold = 1; m_pre = 1'b1;
      end else begin
        m_hold++;
      end
    end
    e.g = (m_own < 0) ? 3'b000 : 3'(1 << m_own);
    e.s = 2'(m_sel);
    e.b = m_own >= 0;
    e.p = m_pre;
    sb.push_back(e);
  endtask
  task automatic drive(input logic r_rst, input logic [2:0] r_req, input logic r_done, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r_rst; req = r_req; done = r_done;
      model_step(r_rst, r_req, r_done);
      @(posedge clk);
      #2;
    end
  endtask
  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt", int'(gnt), int'(e.g));
        chk("select", int'(sel), int'(e.s));
        chk("busy", int'(busy), int'(e.b));
        chk("preempt", int'(preempt), int'(e.p));
      end
    end
  end
  initial begin
    drive(1'b1, 3'b111, 1'b1, 2);
    drive(1'b0, 3'b111, 1'b0, 3);
    for (int i = 0; i < 10; i++) drive(1'b0, 3'b111, 1'(i % 2), 1);
    drive(1'b0, 3'b000, 1'b0, 2);
    drive(1'b0, 3'b010, 1'b0, 3);
    drive(1'b0, 3'b010, 1'b1, 1);
    drive(1'b0, 3'b010, 1'b0, 2);
    drive(1'b0, 3'b000, 1'b0, 2);
    drive(1'b0, 3'b011, 1'b0, 12);
    drive(1'b0, 3'b000, 1'b0, 1);
    drive(1'b0, 3'b001, 1'b0, 25);
    drive(1'b0, 3'b000, 1'b0, 1);
    drive(1'b0, 3'b100, 1'b0, 2);
    drive(1'b0, 3'b101, 1'b0, 2);
    drive(1'b0, 3'b001, 1'b0, 2);
    drive(1'b0, 3'b000, 1'b0, 1);
    drive(1'b0, 3'b010, 1'b0, 3);
    drive(1'b1, 3'b111, 1'b0, 1);
    drive(1'b0, 3'b111, 1'b0, 3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 199) == 0), req, 1'($urandom_range(0, 3) == 0), 1);
    end
    repeat (3) @(posedge clk);
    #3;
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_3to1.md
Name: rr_arbiter_3to1

Overview:
- Sequential round-robin arbiter that shares one resource among three requesters, e.g. a data-memory port or write-back bus.
- Drives the 2-bit select of the downstream 3-to-1 mux with the 00/01/10 encoding.
- Provides one-hot grants, holds ownership until the owner signals completion, and preempts an owner that exceeds a hold limit while others wait.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner while another requester is pending. Legal range is 1 to 2^CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  3  request per requester; bit n belongs to requester n.
- done_i  input  1  the current owner's transaction completes this cycle.
- gnt_o  output  3  one-hot grant, registered.
- select_o  output  2  mux select: 00, 01 or 10 for owner 0, 1 or 2. Never 11.
- busy_o  output  1  high while a grant is active (state GRANT).
- preempt_o  output  1  one-cycle pulse on the cycle after a forced rotation.

Behaviour:
- Reset, checked on the clock edge only:
  - gnt_o=000, select_o=00, busy_o=0, preempt_o=0.
  - State IDLE, priority pointer ptr=0, hold counter cnt=0.
  - Reset overrides all other inputs, including in the middle of a grant.
- Arbitration function, win(p):
  - Scan req_i in the order p, p+1, p+2 (mod 3). The first set bit wins.
  - If no bit is set, there is no winner.
- State IDLE:
  - If req_i != 0, at the next edge: gnt_o = onehot(win(ptr)), select_o = win(ptr), busy_o=1, cnt=0, go to GRANT.
  - Grant latency is one cycle from the first sampled request.
  - done_i is ignored in IDLE.
  - select_o holds the last owner's index so the mux output stays stable.
- State GRANT, owner o, evaluated each edge in priority order:
  1. Release: done_i=1, or req_i[o]=0 (abort).
     - Set ptr = o+1 mod 3 and evaluate w = win(o+1) on the same cycle's req_i.
     - If w exists: gnt_o=onehot(w), select_o=w, cnt=0, stay in GRANT. This gives back-to-back hand-over with no idle bubble. w may equal o again if o is the only requester.
     - If no w: gnt_o=000, busy_o=0, go to IDLE. select_o keeps o.
  2. Preempt: cnt == MAX_HOLD-1 and (req_i & ~onehot(o)) != 0.
     - Apply the same hand-over as release, but the winner is taken from the other requesters only (never o).
     - preempt_o=1 for the next cycle.
     - The owner loses its grant without done_i; re-requesting is the owner's responsibility.
  3. Otherwise: hold the grant. cnt increments and saturates at MAX_HOLD-1.
     - With no competing requests, an owner may hold indefinitely.
- Invariants:
  - gnt_o is zero or one-hot.
  - gnt_o and select_o always agree while busy_o=1.
  - busy_o == (gnt_o != 0).
- All outputs are registered; nothing combinational runs from req_i to gnt_o.
- Counter arithmetic is unsigned CNT_W-bit. MAX_HOLD=1 means rotation every cycle under contention.

Test Plan:
- Reset: rst_i=1 for 2 cycles with req_i=111 and done_i=1 -> gnt_o=000, select_o=00, busy_o=0, preempt_o=0. The first grant appears one cycle after rst_i falls and goes to requester 0.
- Single requester: req_i=010 from cycle 0 -> cycle 1 gnt_o=010, select_o=01, busy_o=1. A done_i pulse at cycle 3 with req still 010 -> gnt stays 010 with no gap and cnt restarts. Dropping req_i at cycle 6 -> cycle 7 gnt_o=000, busy_o=0, select_o=01.
- Round-robin fairness: req_i=111 held, owner asserts done_i on its 2nd grant cycle -> owners 0,1,2,0,1 with select_o 00,01,10,00,01, each granted for exactly 2 cycles, no idle cycles between.
- Preemption (MAX_HOLD=4): req_i=011, done_i=0 throughout -> gnt_o=001 for exactly 4 cycles, then 010 with preempt_o=1 for one cycle. Repeat with req_i=001 only -> gnt_o=001 held for 20+ cycles with no preempt.
- Abort with pointer wrap: owner 2 granted, req_i changes 101 -> 001 without done_i -> next cycle gnt_o=001, select_o=00, ptr=0.
- Reset mid-grant: owner 1 in its 3rd grant cycle, pulse rst_i for 1 cycle with req_i=111 -> next cycle all outputs at reset values. The following grant goes to requester 0, not 2.
